// File: rtl/mips_mc_seq.sv
// Multicycle control sequencer for the Tiny MIPS datapath: walks each instruction
// through fetch/decode/exec/mem/writeback and issues the per-register enables.
module mips_mc_seq #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        dec_wreg,
  input  logic        dec_wmem,
  input  logic        dec_m2reg,
  input  logic [1:0]  dec_pcsrc,
  input  logic        dec_illegal,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        alu_en,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        r_err;
  logic [31:0] r_instret;
  logic        w_commit;
  logic        w_set_err;
  logic        w_wait_hit;
  logic        w_stall;

  // A not-taken conditional branch falls through to PC+4.
  function automatic logic [1:0] f_pc_sel(input logic [1:0] src, input logic taken);
    if (src == 2'b01 && !taken) begin
      return 2'b00;
    end
    return src;
  endfunction

  assign w_wait_hit = (r_wait == TIMEOUT);
  assign w_stall    = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_set_err = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_wait_hit) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (dec_wmem || dec_m2reg) begin
          w_next = S_MEM;
        end else if (dec_wreg) begin
          w_next = S_WB;
        end else begin
          w_commit = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_wmem;
        if (dmem_ack) begin
          if (dec_m2reg) begin
            mdr_we = 1'b1;
            w_next = S_WB;
          end else begin
            w_commit = 1'b1;
          end
        end else if (w_wait_hit) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        w_commit = 1'b1;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Retirement: one PC update, then straight back to fetch unless run was withdrawn.
    if (w_commit) begin
      pc_we  = 1'b1;
      pc_sel = f_pc_sel(dec_pcsrc, br_taken);
      w_next = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= 8'd0;
      r_err     <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= 8'd0;
      end else if (w_stall) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_commit) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign state   = r_state;
  assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign err     = r_err;
  assign instret = r_instret;

endmodule

// File: tb/tb_mips_mc_seq.sv
// Randomized bench for mips_mc_seq: a driver issues instructions and memory latencies,
// a monitor pops expected retire/halt records and compares observed behaviour.
module tb_mips_mc_seq;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        dec_wreg;
  logic        dec_wmem;
  logic        dec_m2reg;
  logic [1:0]  dec_pcsrc;
  logic        dec_illegal;
  logic        br_taken;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        ir_we;
  logic        alu_en;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        busy;
  logic        err;
  logic [2:0]  state;
  logic [31:0] instret;

  mips_mc_seq #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .dec_wreg(dec_wreg), .dec_wmem(dec_wmem), .dec_m2reg(dec_m2reg),
    .dec_pcsrc(dec_pcsrc), .dec_illegal(dec_illegal), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .alu_en(alu_en), .mdr_we(mdr_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy), .err(err),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit halt;
    int psel;
    int cyc;
    int ireq;
    int ir;
    int alu;
    int st;
    int ld;
    int mdr;
    int rf;
    int iret;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_ret = 0;

  function automatic void chk(string name, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Monitor: accumulates per-instruction activity from FETCH entry, compares on retire or halt.
  int         m_cyc, m_ireq, m_ir, m_alu, m_st, m_ld, m_mdr, m_rf;
  logic [2:0] m_prev = 3'd0;
  exp_t       m_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (state == 3'd1 && m_prev != 3'd1) begin
        m_cyc = 0; m_ireq = 0; m_ir = 0; m_alu = 0;
        m_st = 0; m_ld = 0; m_mdr = 0; m_rf = 0;
      end
      if (busy) begin
        m_cyc++;
        m_ireq += int'(imem_req);
        m_ir   += int'(ir_we);
        m_alu  += int'(alu_en);
        m_st   += int'(dmem_req && dmem_we);
        m_ld   += int'(dmem_req && !dmem_we);
        m_mdr  += int'(mdr_we);
        m_rf   += int'(rf_we);
      end
      if (pc_we) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("commit_vs_halt", 0, m_e.halt);
          chk("pc_sel", pc_sel, m_e.psel);
          chk("cycles", m_cyc, m_e.cyc);
          chk("imem_req_cycles", m_ireq, m_e.ireq);
          chk("ir_we_count", m_ir, m_e.ir);
          chk("alu_en_count", m_alu, m_e.alu);
          chk("store_req_cycles", m_st, m_e.st);
          chk("load_req_cycles", m_ld, m_e.ld);
          chk("mdr_we_count", m_mdr, m_e.mdr);
          chk("rf_we_count", m_rf, m_e.rf);
          chk("instret", instret, m_e.iret);
        end
      end
      if (state == 3'd6 && m_prev != 3'd6) begin
        if (q.size() == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("halt_vs_commit", 1, m_e.halt);
          chk("halt_err", err, 1);
          chk("halt_cycles", m_cyc, m_e.cyc);
          chk("halt_imem_req_cycles", m_ireq, m_e.ireq);
          chk("halt_ir_we_count", m_ir, m_e.ir);
          chk("halt_alu_en_count", m_alu, m_e.alu);
          chk("halt_store_req_cycles", m_st, m_e.st);
          chk("halt_load_req_cycles", m_ld, m_e.ld);
          chk("halt_rf_we_count", m_rf, m_e.rf);
          chk("halt_instret", instret, m_e.iret);
        end
      end
      m_prev = state;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    chk("rst_state", state, 0);
    chk("rst_err", err, 0);
    chk("rst_instret", instret, 0);
    chk("rst_busy", busy, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_queue_drained", q.size(), 0);
    q.delete();
    rst = 1'b0;
    n_ret = 0;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return MT + 1;
    if (r == 1) return MT;
    return r % 3;
  endfunction

  task automatic run_instr();
    int kind, iw, dw, icnt, dcnt;
    bit drop, brt, done, halted, is_ld, is_st, is_wb;
    exp_t e;
    kind = $urandom_range(0, 9);
    iw   = pick_wait();
    dw   = pick_wait();
    brt  = 1'($urandom_range(0, 1));
    drop = ($urandom_range(0, 4) == 0);
    dec_illegal = 1'b0; dec_wreg = 1'b0; dec_wmem = 1'b0; dec_m2reg = 1'b0; dec_pcsrc = 2'b00;
    case (kind)
      0, 1:    dec_wreg = 1'b1;
      2:       begin dec_wreg = 1'b1; dec_pcsrc = 2'b10; end
      3:       begin dec_wreg = 1'b1; dec_m2reg = 1'b1; end
      4:       dec_wmem = 1'b1;
      5, 6:    dec_pcsrc = 2'b01;
      7:       dec_pcsrc = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
      8:       dec_pcsrc = 2'b00;
      default: begin
        dec_illegal = 1'b1;
        dec_wreg    = 1'($urandom_range(0, 1));
        dec_pcsrc   = 2'($urandom_range(0, 3));
      end
    endcase
    br_taken = brt;

    // Reference: phase costs are fixed, each memory wait adds one cycle, a wait past MT halts.
    is_ld = (kind == 3);
    is_st = (kind == 4);
    is_wb = (kind <= 3);
    e = '{halt: 1'b0, psel: 0, cyc: 0, ireq: 0, ir: 0, alu: 0, st: 0, ld: 0, mdr: 0, rf: 0, iret: n_ret};
    if (iw > MT) begin
      e.halt = 1'b1; e.cyc = MT + 1; e.ireq = MT + 1;
    end else if (kind == 9) begin
      e.halt = 1'b1; e.cyc = iw + 2; e.ireq = iw + 1; e.ir = 1;
    end else if ((is_ld || is_st) && dw > MT) begin
      e.halt = 1'b1; e.cyc = iw + 1 + 2 + MT + 1; e.ireq = iw + 1; e.ir = 1; e.alu = 1;
      if (is_st) e.st = MT + 1; else e.ld = MT + 1;
    end else begin
      e.ireq = iw + 1; e.ir = 1; e.alu = 1;
      e.cyc  = iw + 1 + 2 + ((is_ld || is_st) ? dw + 1 : 0) + (is_wb ? 1 : 0);
      if (is_st) e.st = dw + 1;
      if (is_ld) begin e.ld = dw + 1; e.mdr = 1; end
      e.rf   = is_wb ? 1 : 0;
      e.psel = (dec_pcsrc == 2'b01) ? (brt ? 1 : 0) : int'(dec_pcsrc);
      n_ret++;
    end
    q.push_back(e);

    run = 1'b1;
    if (state == 3'd0) tick();
    icnt = 0; dcnt = 0; done = 1'b0; halted = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      imem_ack = imem_req && (icnt == iw);
      dmem_ack = dmem_req && (dcnt == dw);
      if (drop && c == 1) run = 1'b0;
      @(negedge clk);
      if (pc_we) done = 1'b1;
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      tick();
      if (state == 3'd6) begin done = 1'b1; halted = 1'b1; end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) begin
      chk("instr_cycle_budget", 0, 1);
      do_reset();
    end else if (halted) begin
      do_reset();
    end else begin
      chk("post_commit_state", state, drop ? 0 : 1);
    end
  endtask

  initial begin : driver
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_wreg = 1'b0; dec_wmem = 1'b0; dec_m2reg = 1'b0; dec_pcsrc = 2'b00;
    dec_illegal = 1'b0; br_taken = 1'b0;
    tick();
    do_reset();

    // Reset while a fetch is outstanding; the ack landing on the reset edge must be ignored.
    run = 1'b1;
    tick();
    tick();
    tick();
    chk("midfetch_req", imem_req, 1);
    rst = 1'b1; imem_ack = 1'b1;
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_imem_req", imem_req, 0);
    chk("midrst_instret", instret, 0);
    rst = 1'b0; imem_ack = 1'b0; run = 1'b0;
    tick();
    chk("midrst_idle_hold", state, 0);

    for (int i = 0; i < 150; i++) begin
      run_instr();
    end
    tick();
    tick();
    chk("final_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
